retire_monitor: RTL and testbench

//   Sits at the tail of the 32-bit ARM pipeline, on the write-back stage outputs, inside dataPath.
//   - Counts retired instructions, active cycles and stall cycles.
//   - Detects the program-end instruction.
//   - Drains the pipeline, then raises a sticky stop to the bench.
//   - Watchdog: ends the run if nothing retires for too long.

---
 rtl/retire_monitor_if.sv | 23 ++
 rtl/retire_monitor.sv | 115 +++++++++++
 tb/tb_retire_monitor.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/retire_monitor_if.sv
// Write-back slot bus as seen by the retire monitor at the tail of the pipeline.
// The pipeline (master) presents one slot per clock; the monitor (slave) samples every edge
// and cannot push back. wb_valid qualifies the slot and wb_flush squashes it.
interface retire_monitor_if;
  logic        wb_valid;
  logic        wb_flush;
  logic [31:0] wb_inst;
  logic        stall;

  modport master (
    output wb_valid,
    output wb_flush,
    output wb_inst,
    output stall
  );

  modport slave (
    input wb_valid,
    input wb_flush,
    input wb_inst,
    input stall
  );
endinterface

// File: rtl/retire_monitor.sv
// Retirement/cycle/stall counters, program-end detection with drain, and a no-retire watchdog.
// Once stop is raised the block is frozen until reset.
module retire_monitor #(
  parameter int          CNT_W        = 32,
  parameter logic [31:0] HALT_INST    = 32'hEAFFFFFE,
  parameter int          DRAIN_CYCLES = 4,
  parameter int          TIMEOUT      = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  retire_monitor_if.slave   wb,
  output logic [CNT_W-1:0]  inst_count,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  stall_count,
  output logic              stop,
  output logic              timeout,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int DR_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [DR_W-1:0] DR_LAST = DR_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  state_t          state;
  logic [WD_W-1:0] wd_cnt;
  logic [DR_W-1:0] drain_cnt;

  logic retire;
  logic is_halt;
  logic wd_expire;

  assign retire    = wb.wb_valid & ~wb.wb_flush;
  assign is_halt   = retire & (wb.wb_inst == HALT_INST);
  // A retiring halt can never also expire the watchdog, so halt wins by construction.
  assign wd_expire = ~retire & (wd_cnt == WD_LAST);
  assign dbg_state = state;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && (v != {CNT_W{1'b1}}))
      return v + CNT_W'(1);
    return v;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      inst_count  <= '0;
      cycle_count <= '0;
      stall_count <= '0;
      stop        <= 1'b0;
      timeout     <= 1'b0;
      wd_cnt      <= '0;
      drain_cnt   <= '0;
    end else if (en) begin
      case (state)
        IDLE: begin
          state <= RUN;
        end

        RUN: begin
          cycle_count <= sat_inc(cycle_count, 1'b1);
          stall_count <= sat_inc(stall_count, wb.stall);
          inst_count  <= sat_inc(inst_count, retire);
          if (retire)
            wd_cnt <= '0;
          else if (!wd_expire)
            wd_cnt <= wd_cnt + WD_W'(1);

          if (is_halt) begin
            drain_cnt <= '0;
            if (DRAIN_CYCLES == 0) begin
              state <= DONE;
              stop  <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else if (wd_expire) begin
            state   <= DONE;
            stop    <= 1'b1;
            timeout <= 1'b1;
          end
        end

        DRAIN: begin
          // In-flight slots are still clocked out, but nothing past the halt is counted.
          cycle_count <= sat_inc(cycle_count, 1'b1);
          if (drain_cnt == DR_LAST) begin
            state <= DONE;
            stop  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DR_W'(1);
          end
        end

        DONE: begin
          state <= DONE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_retire_monitor.sv
// Bench for retire_monitor: instance A (32-bit counters, 4-cycle drain, watchdog 8) and
// instance B (4-bit counters, no drain) share the write-back bus; the idle one is held in reset.
module tb_retire_monitor;

  localparam logic [31:0] HALT = 32'hEAFFFFFE;
  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_DRAIN = 2'd2;
  localparam logic [1:0]  S_DONE = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, en_a, rst_b, en_b;
  retire_monitor_if wb();

  logic [31:0] inst_a, cyc_a, stl_a;
  logic        stop_a, to_a;
  logic [1:0]  st_a;
  logic [3:0]  inst_b, cyc_b, stl_b;
  logic        stop_b, to_b;
  logic [1:0]  st_b;

  retire_monitor #(.CNT_W(32), .HALT_INST(HALT), .DRAIN_CYCLES(4), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .wb(wb),
    .inst_count(inst_a), .cycle_count(cyc_a), .stall_count(stl_a),
    .stop(stop_a), .timeout(to_a), .dbg_state(st_a)
  );

  retire_monitor #(.CNT_W(4), .HALT_INST(HALT), .DRAIN_CYCLES(0), .TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .wb(wb),
    .inst_count(inst_b), .cycle_count(cyc_b), .stall_count(stl_b),
    .stop(stop_b), .timeout(to_b), .dbg_state(st_b)
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic f, input logic [31:0] inst, input logic s);
    wb.wb_valid = v;
    wb.wb_flush = f;
    wb.wb_inst  = inst;
    wb.stall    = s;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = 32'($urandom_range(0, 32'h7FFFFFFF));
    return r;
  endfunction

  task automatic start_a();
    wb.wb_valid = 1'b0; wb.wb_flush = 1'b0; wb.wb_inst = '0; wb.stall = 1'b0;
    en_a = 1'b0; en_b = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
    @(posedge clk); #1;
    rst_a = 1'b1; en_a = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic start_b();
    wb.wb_valid = 1'b0; wb.wb_flush = 1'b0; wb.wb_inst = '0; wb.stall = 1'b0;
    en_a = 1'b0; en_b = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1; en_b = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    start_a();
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, rand_inst(), 1'b0);
    n_cmp++; if (inst_a !== 32'd7) begin n_fail++; $display("FAIL reset_pre_inst: got %0d want 7", inst_a); end
    #2 rst_a = 1'b0;
    #1;
    n_cmp++; if (inst_a !== 32'd0) begin n_fail++; $display("FAIL reset_inst: got %0d want 0", inst_a); end
    n_cmp++; if (cyc_a !== 32'd0) begin n_fail++; $display("FAIL reset_cycle: got %0d want 0", cyc_a); end
    n_cmp++; if (stl_a !== 32'd0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", stl_a); end
    n_cmp++; if ({stop_a, to_a} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {stop_a, to_a}); end
    rst_a = 1'b1;
    #1;
    n_cmp++; if (st_a !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", st_a, S_IDLE); end
    en_a = 1'b0;
    drive(1'b1, 1'b0, rand_inst(), 1'b1);
    n_cmp++; if ({st_a, inst_a} !== {S_IDLE, 32'd0}) begin n_fail++; $display("FAIL reset_idle_hold: got state %0d inst %0d want 0/0", st_a, inst_a); end
  endtask

  task automatic test_basic_count();
    int k;
    start_a();
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, rand_inst(), 1'b0);
    exp_q.push_back(32'd11); exp_q.push_back(32'd0); exp_q.push_back(32'd15);
    drive(1'b1, 1'b0, HALT, 1'b0);
    n_cmp++; if (st_a !== S_DRAIN) begin n_fail++; $display("FAIL basic_drain_state: got %0d want %0d", st_a, S_DRAIN); end
    k = 0;
    while (stop_a !== 1'b1 && k < 20) begin drive(1'b1, 1'b0, rand_inst(), 1'b1); k++; end
    n_cmp++; if (k != 4) begin n_fail++; $display("FAIL basic_latency: got %0d edges want 4", k); end
    exp_v = exp_q.pop_front();
    n_cmp++; if (inst_a !== exp_v) begin n_fail++; $display("FAIL basic_inst: got %0d want %0d", inst_a, exp_v); end
    exp_v = exp_q.pop_front();
    n_cmp++; if (stl_a !== exp_v) begin n_fail++; $display("FAIL basic_stall: got %0d want %0d", stl_a, exp_v); end
    exp_v = exp_q.pop_front();
    n_cmp++; if (cyc_a !== exp_v) begin n_fail++; $display("FAIL basic_cycle: got %0d want %0d", cyc_a, exp_v); end
    n_cmp++; if (to_a !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %b want 0", to_a); end
    // DONE must ignore further traffic and en.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, HALT, 1'b1);
    en_a = 1'b0; drive(1'b1, 1'b0, rand_inst(), 1'b1); en_a = 1'b1;
    n_cmp++; if ({stop_a, inst_a, stl_a, cyc_a} !== {1'b1, 32'd11, 32'd0, 32'd15}) begin
      n_fail++; $display("FAIL done_sticky: got stop %b inst %0d stall %0d cyc %0d want 1/11/0/15", stop_a, inst_a, stl_a, cyc_a);
    end
  endtask

  task automatic test_flush_stall();
    // {valid, flush, stall}: 6 retirements, 5 flushed slots, 3 stall-only cycles.
    logic [2:0] tbl [14] = '{3'b100, 3'b110, 3'b001, 3'b100, 3'b110, 3'b100, 3'b001,
                            3'b110, 3'b100, 3'b110, 3'b100, 3'b001, 3'b110, 3'b100};
    logic [31:0] ei, es, ec;
    int k;
    start_a();
    ei = 0; es = 0; ec = 0;
    for (int i = 0; i < 14; i++) begin
      // A flushed halt must not end the run.
      drive(tbl[i][2], tbl[i][1], (tbl[i][1] ? HALT : rand_inst()), tbl[i][0]);
      if (tbl[i][2] && !tbl[i][1]) ei++;
      if (tbl[i][0]) es++;
      ec++;
    end
    n_cmp++; if (stop_a !== 1'b0 || st_a === S_DRAIN) begin n_fail++; $display("FAIL flushed_halt: got stop %b state %0d want running", stop_a, st_a); end
    en_a = 1'b0;
    drive(1'b1, 1'b0, rand_inst(), 1'b1);
    drive(1'b1, 1'b0, HALT, 1'b1);
    en_a = 1'b1;
    n_cmp++; if ({inst_a, stl_a, cyc_a} !== {ei, es, ec}) begin
      n_fail++; $display("FAIL run_freeze: got %0d/%0d/%0d want %0d/%0d/%0d", inst_a, stl_a, cyc_a, ei, es, ec);
    end
    drive(1'b1, 1'b0, HALT, 1'b0);
    ei++; ec++;
    exp_q.push_back(ei); exp_q.push_back(es); exp_q.push_back(ec + 32'd4);
    k = 0;
    while (stop_a !== 1'b1 && k < 20) begin drive(1'b0, 1'b0, '0, 1'b0); k++; end
    exp_v = exp_q.pop_front();
    n_cmp++; if (inst_a !== exp_v || exp_v !== 32'd7) begin n_fail++; $display("FAIL mix_inst: got %0d want %0d", inst_a, exp_v); end
    exp_v = exp_q.pop_front();
    n_cmp++; if (stl_a !== exp_v || exp_v !== 32'd3) begin n_fail++; $display("FAIL mix_stall: got %0d want %0d", stl_a, exp_v); end
    exp_v = exp_q.pop_front();
    n_cmp++; if (cyc_a !== exp_v) begin n_fail++; $display("FAIL mix_cycle: got %0d want %0d", cyc_a, exp_v); end
  endtask

  task automatic test_watchdog();
    int k;
    start_a();
    drive(1'b1, 1'b0, rand_inst(), 1'b0);
    exp_q.push_back(32'd1); exp_q.push_back(32'd9);
    k = 0;
    while (stop_a !== 1'b1 && k < 20) begin drive(1'b0, 1'b0, '0, 1'b0); k++; end
    n_cmp++; if (k != 8) begin n_fail++; $display("FAIL wd_latency: got %0d idle edges want 8", k); end
    n_cmp++; if (to_a !== 1'b1) begin n_fail++; $display("FAIL wd_timeout: got %b want 1", to_a); end
    exp_v = exp_q.pop_front();
    n_cmp++; if (inst_a !== exp_v) begin n_fail++; $display("FAIL wd_inst: got %0d want %0d", inst_a, exp_v); end
    exp_v = exp_q.pop_front();
    n_cmp++; if (cyc_a !== exp_v) begin n_fail++; $display("FAIL wd_cycle: got %0d want %0d", cyc_a, exp_v); end
    n_cmp++; if (st_a !== S_DONE) begin n_fail++; $display("FAIL wd_state: got %0d want %0d", st_a, S_DONE); end
  endtask

  task automatic test_halt_on_expiry_freeze();
    int e;
    start_a();
    drive(1'b1, 1'b0, rand_inst(), 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b0, '0, 1'b0);
    n_cmp++; if (stop_a !== 1'b0) begin n_fail++; $display("FAIL wd_early: got stop %b want 0", stop_a); end
    drive(1'b1, 1'b0, HALT, 1'b0);
    exp_q.push_back(32'd2); exp_q.push_back(32'd13);
    n_cmp++; if ({st_a, to_a, stop_a} !== {S_DRAIN, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL halt_wins: got state %0d timeout %b stop %b want 2/0/0", st_a, to_a, stop_a);
    end
    drive(1'b1, 1'b0, rand_inst(), 1'b1);
    en_a = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, rand_inst(), 1'b1);
    en_a = 1'b1;
    e = 4;
    while (stop_a !== 1'b1 && e < 30) begin drive(1'b1, 1'b0, rand_inst(), 1'b1); e++; end
    n_cmp++; if (e != 7) begin n_fail++; $display("FAIL drain_freeze_latency: got %0d edges want 7", e); end
    exp_v = exp_q.pop_front();
    n_cmp++; if (inst_a !== exp_v) begin n_fail++; $display("FAIL drain_inst: got %0d want %0d", inst_a, exp_v); end
    exp_v = exp_q.pop_front();
    n_cmp++; if (cyc_a !== exp_v) begin n_fail++; $display("FAIL drain_cycle: got %0d want %0d", cyc_a, exp_v); end
    n_cmp++; if (to_a !== 1'b0) begin n_fail++; $display("FAIL drain_timeout: got %b want 0", to_a); end
  endtask

  task automatic test_saturate_drain0();
    start_b();
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, rand_inst(), (i < 3));
    exp_q.push_back(32'hF); exp_q.push_back(32'd3); exp_q.push_back(32'hF);
    n_cmp++; if ({stop_b, inst_b} !== {1'b0, 4'hF}) begin n_fail++; $display("FAIL sat_pre: got stop %b inst %h want 0/f", stop_b, inst_b); end
    drive(1'b1, 1'b0, HALT, 1'b0);
    n_cmp++; if ({stop_b, to_b, st_b} !== {1'b1, 1'b0, S_DONE}) begin
      n_fail++; $display("FAIL drain0_stop: got stop %b timeout %b state %0d want 1/0/3", stop_b, to_b, st_b);
    end
    exp_v = exp_q.pop_front();
    n_cmp++; if ({28'd0, inst_b} !== exp_v) begin n_fail++; $display("FAIL sat_inst: got %h want %h", inst_b, exp_v); end
    exp_v = exp_q.pop_front();
    n_cmp++; if ({28'd0, stl_b} !== exp_v) begin n_fail++; $display("FAIL sat_stall: got %h want %h", stl_b, exp_v); end
    exp_v = exp_q.pop_front();
    n_cmp++; if ({28'd0, cyc_b} !== exp_v) begin n_fail++; $display("FAIL sat_cycle: got %h want %h", cyc_b, exp_v); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b0; en_b = 1'b0;
    wb.wb_valid = 1'b0; wb.wb_flush = 1'b0; wb.wb_inst = '0; wb.stall = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_basic_count();
    test_flush_stall();
    test_watchdog();
    test_halt_on_expiry_freeze();
    test_saturate_drain0();
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got no end of run want finish before 200000ns");
    $fatal(1, "time limit");
  end

endmodule
